// File: rtl/cache_dfp_arbiter_pkg.sv
// Shared types for the two-requester downstream memory port arbiter.
// Combinational helpers only; no state, no backpressure.
package cache_dfp_arbiter_pkg;

  localparam int NUM_DFP_REQ = 2;
  localparam int ADDR_W      = 32;
  localparam int LINE_W      = 256;
  localparam int WDOG_W      = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DRAIN
  } arb_state_t;

  // Command held toward memory for the whole BUSY state.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
  } dfp_cmd_t;

  function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_dfp_arbiter_if.sv
// Requester-side and memory-side bundle of the arbiter; slave = arbiter view, master = environment view.
// Level requests held until a one-cycle resp; no other flow control.
interface cache_dfp_arbiter_if;
  import cache_dfp_arbiter_pkg::*;

  logic [NUM_DFP_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_DFP_REQ-1:0]             req_read;
  logic [NUM_DFP_REQ-1:0]             req_write;
  logic [NUM_DFP_REQ-1:0][LINE_W-1:0] req_wdata;
  logic [NUM_DFP_REQ-1:0][LINE_W-1:0] req_rdata;
  logic [NUM_DFP_REQ-1:0]             req_resp;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_addr, req_read, req_write, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_addr, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/cache_dfp_arbiter_rr_pick.sv
// Two-way round-robin pick: lone requester wins, a tie goes to the port that did not win last.
// Purely combinational, zero latency; no backpressure.
module arb_rr_pick
  import cache_dfp_arbiter_pkg::*;
(
  input  logic [NUM_DFP_REQ-1:0] req,
  input  logic                   last_owner,
  output logic                   grant,
  output logic                   valid
);

  always_comb begin
    valid = |req;
    if (&req) begin
      grant = ~last_owner;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/cache_dfp_arbiter.sv
// Grants one of two cache requesters onto the memory port; command registered 1 cycle after request.
// Requests are level-held until req_resp; a one-cycle DRAIN lets the owner drop before re-arbitration.
module cache_dfp_arbiter
  import cache_dfp_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_dfp_arbiter_if.slave    bus,
  output logic                  arb_timeout
);

  localparam int                TO_CLAMP    = (TIMEOUT > 65535) ? 65535 : TIMEOUT;
  localparam logic [WDOG_W-1:0] TIMEOUT_CNT = WDOG_W'(TO_CLAMP);
  localparam logic              WDOG_EN     = (TIMEOUT != 0);

  arb_state_t                state;
  logic                      owner;
  logic                      last_owner;
  dfp_cmd_t                  cmd;
  logic [WDOG_W-1:0]         wdog_cnt;

  logic [NUM_DFP_REQ-1:0]    req_vec;
  logic                      pick_grant;
  logic                      pick_vld;
  logic [WDOG_W-1:0]         wdog_next;
  logic                      wdog_hit;
  logic [NUM_DFP_REQ-1:0]    resp_vec;

  arb_rr_pick u_pick (
    .req        (req_vec),
    .last_owner (last_owner),
    .grant      (pick_grant),
    .valid      (pick_vld)
  );

  always_comb begin
    req_vec   = bus.req_read | bus.req_write;
    wdog_next = sat_inc(wdog_cnt);
    wdog_hit  = WDOG_EN && (wdog_next >= TIMEOUT_CNT);

    // Responses outside BUSY are strays (e.g. after a mid-transaction reset) and are dropped.
    resp_vec = '0;
    if (bus.mem_resp && (state == ARB_BUSY)) begin
      resp_vec[owner] = 1'b1;
    end

    bus.req_resp  = resp_vec;
    bus.req_rdata = {NUM_DFP_REQ{bus.mem_rdata}};
    bus.mem_addr  = cmd.addr;
    bus.mem_read  = cmd.read;
    bus.mem_write = cmd.write;
    bus.mem_wdata = cmd.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      cmd         <= '0;
      wdog_cnt    <= '0;
      arb_timeout <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            // Read and write together from one port is resolved as a write.
            cmd.addr   <= bus.req_addr[pick_grant];
            cmd.write  <= bus.req_write[pick_grant];
            cmd.read   <= bus.req_read[pick_grant] & ~bus.req_write[pick_grant];
            cmd.wdata  <= bus.req_wdata[pick_grant];
            owner      <= pick_grant;
            last_owner <= pick_grant;
            wdog_cnt   <= '0;
            state      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          wdog_cnt <= wdog_next;
          if (wdog_hit) begin
            arb_timeout <= 1'b1;
          end
          if (bus.mem_resp) begin
            cmd.read  <= 1'b0;
            cmd.write <= 1'b0;
            state     <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_dfp_arbiter.sv
// Bench for cache_dfp_arbiter: directed scenarios plus randomized traffic against a cycle-level reference.
// Requesters and memory are behavioural; the reference tracks grants, timing and the watchdog.
module tb_cache_dfp_arbiter;
  import cache_dfp_arbiter_pkg::*;

  localparam int TO = 8;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
    int           delay;
  } rq_t;

  typedef struct {
    int           cyc;
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [255:0] wdata;
  } cmd_log_t;

  logic clk = 1'b0;
  logic rst;
  logic arb_timeout;

  always #5 clk = ~clk;

  cache_dfp_arbiter_if bus();

  cache_dfp_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .arb_timeout (arb_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int resp_cnt[2] = '{0, 0};
  always @(negedge clk) begin
    if (bus.req_resp[0] === 1'b1) resp_cnt[0] = resp_cnt[0] + 1;
    if (bus.req_resp[1] === 1'b1) resp_cnt[1] = resp_cnt[1] + 1;
  end

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Requester / memory environment and reference state.
  rq_t          rq_q[2][$];
  int           lat_q[$];
  logic [255:0] rdata_q[$];
  cmd_log_t     dut_log[$];
  int           resp_log[$];
  logic         active[2];
  rq_t          cur[2];
  int           wait_cnt[2];
  logic         drop_next[2];
  logic         req_prev[2];
  logic         cmd_active, pred, resp_prev, busy_prev, exp_to, m_last, m_owner, dut_cmd_prev;
  rq_t          cmd;
  int           exp_start, free_at, lat_cnt, busy_cycles, to_rise;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic rq_t mk_rq(input logic [31:0] addr, input logic wr,
                                input logic [255:0] wdata, input int delay);
    rq_t r;
    r.addr  = addr;
    r.wr    = wr;
    r.wdata = wdata;
    r.delay = delay;
    return r;
  endfunction

  task automatic drive_ports();
    for (int i = 0; i < 2; i++) begin
      bus.req_read[i]  = active[i] && !cur[i].wr;
      bus.req_write[i] = active[i] && cur[i].wr;
      bus.req_addr[i]  = cur[i].addr;
      bus.req_wdata[i] = cur[i].wdata;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst           = 1'b1;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    bus.req_read  = '0;
    bus.req_write = '0;
    for (int i = 0; i < 2; i++) begin
      active[i]    = 1'b0;
      drop_next[i] = 1'b0;
      wait_cnt[i]  = -1;
      req_prev[i]  = 1'b0;
      rq_q[i].delete();
    end
    lat_q.delete();
    rdata_q.delete();
    dut_log.delete();
    resp_log.delete();
    cmd_active = 1'b0; pred = 1'b0; resp_prev = 1'b0; busy_prev = 1'b0;
    exp_to = 1'b0; m_last = 1'b1; m_owner = 1'b0; dut_cmd_prev = 1'b0;
    busy_cycles = 0; to_rise = -1; lat_cnt = 0;
    @(posedge clk); #1;
    chk("rst_mem_read",  256'(bus.mem_read),  256'(1'b0));
    chk("rst_mem_write", 256'(bus.mem_write), 256'(1'b0));
    chk("rst_mem_addr",  256'(bus.mem_addr),  256'(32'h0));
    chk("rst_mem_wdata", bus.mem_wdata,       256'h0);
    chk("rst_timeout",   256'(arb_timeout),   256'(1'b0));
    chk("rst_req_resp",  256'(bus.req_resp),  256'(2'b00));
    rst     = 1'b0;
    free_at = cyc;
  endtask

  // One iteration per clock at posedge+1: reference grant/memory/requesters, then compare.
  task automatic run(input int budget);
    int           n;
    int           c;
    logic         done;
    logic         winner;
    logic         dut_cmd;
    logic         m_resp;
    logic [1:0]   exp_resp;
    logic [255:0] rd_v;
    cmd_log_t     e;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      c = cyc;
      if (busy_prev) begin
        busy_cycles++;
        if (busy_cycles >= TO) exp_to = 1'b1;
      end
      if (resp_prev) cmd_active = 1'b0;
      if (pred && c == exp_start) begin
        winner      = (req_prev[0] && req_prev[1]) ? ~m_last : req_prev[1];
        cmd_active  = 1'b1;
        m_owner     = winner;
        m_last      = winner;
        cmd         = cur[winner];
        busy_cycles = 0;
        pred        = 1'b0;
        lat_cnt     = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, 5));
      end

      dut_cmd = bus.mem_read | bus.mem_write;
      if (dut_cmd && !dut_cmd_prev) begin
        e.cyc = c; e.addr = bus.mem_addr; e.rd = bus.mem_read;
        e.wr = bus.mem_write; e.wdata = bus.mem_wdata;
        dut_log.push_back(e);
      end
      dut_cmd_prev = dut_cmd;
      if (arb_timeout && to_rise < 0) to_rise = c;

      chk("mem_read",  256'(bus.mem_read),  256'(cmd_active && !cmd.wr));
      chk("mem_write", 256'(bus.mem_write), 256'(cmd_active && cmd.wr));
      if (cmd_active) chk("mem_addr", 256'(bus.mem_addr), 256'(cmd.addr));
      if (cmd_active && cmd.wr) chk("mem_wdata", bus.mem_wdata, cmd.wdata);
      chk("arb_timeout", 256'(arb_timeout), 256'(exp_to));

      m_resp = 1'b0;
      if (cmd_active) begin
        if (lat_cnt == 0) m_resp = 1'b1;
        else lat_cnt--;
      end
      rd_v = (m_resp && rdata_q.size() > 0) ? rdata_q.pop_front() : rand_line();
      bus.mem_resp  = m_resp;
      bus.mem_rdata = rd_v;

      for (int i = 0; i < 2; i++) begin
        if (drop_next[i]) begin
          active[i]    = 1'b0;
          drop_next[i] = 1'b0;
        end else if (!active[i]) begin
          if (wait_cnt[i] < 0 && rq_q[i].size() > 0) begin
            cur[i]      = rq_q[i].pop_front();
            wait_cnt[i] = cur[i].delay;
          end
          if (wait_cnt[i] == 0) begin
            active[i]   = 1'b1;
            wait_cnt[i] = -1;
          end else if (wait_cnt[i] > 0) begin
            wait_cnt[i]--;
          end
        end
      end
      drive_ports();
      #1;

      exp_resp = m_resp ? (2'b01 << m_owner) : 2'b00;
      chk("req_resp", 256'(bus.req_resp), 256'(exp_resp));
      if (m_resp) begin
        chk("req_rdata0", bus.req_rdata[0], rd_v);
        chk("req_rdata1", bus.req_rdata[1], rd_v);
        drop_next[m_owner] = 1'b1;
        free_at = c + 2;
      end
      if (bus.req_resp != 2'b00) resp_log.push_back(c);

      resp_prev = m_resp;
      busy_prev = cmd_active;
      req_prev  = active;
      if (!cmd_active && !pred && c >= free_at && (active[0] || active[1])) begin
        pred      = 1'b1;
        exp_start = c + 1;
      end
      done = !cmd_active && !pred && !active[0] && !active[1] && !drop_next[0] && !drop_next[1]
             && rq_q[0].size() == 0 && rq_q[1].size() == 0 && wait_cnt[0] < 0 && wait_cnt[1] < 0;
      n++;
      if (!done && n >= budget) begin
        chk("engine_budget_idle", 256'(done), 256'(1'b1));
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [255:0] pat_a;
    logic [255:0] pat_b;
    logic [31:0]  r;
    int           base0;
    int           base1;
    rq_t          rq;

    rst           = 1'b1;
    bus.req_addr  = '0;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    pat_a = {8{32'hA5A5_0F0F}};
    pat_b = {8{32'h5A5A_C3C3}};

    // Single port 0 read, memory answers 5 cycles after the command.
    do_reset();
    rq_q[0].push_back(mk_rq(32'h0000_1000, 1'b0, rand_line(), 0));
    lat_q.push_back(5);
    rdata_q.push_back(pat_a);
    base0 = resp_cnt[0];
    base1 = resp_cnt[1];
    run(200);
    chk("t1_cmd_count", 256'(dut_log.size()), 256'(1));
    if (dut_log.size() >= 1) begin
      chk("t1_addr", 256'(dut_log[0].addr), 256'(32'h0000_1000));
      chk("t1_rd",   256'(dut_log[0].rd),   256'(1'b1));
      chk("t1_wr",   256'(dut_log[0].wr),   256'(1'b0));
    end
    if (dut_log.size() >= 1 && resp_log.size() >= 1)
      chk("t1_latency", 256'(resp_log[0] - dut_log[0].cyc), 256'(5));
    chk("t1_resp0_pulses", 256'(resp_cnt[0] - base0), 256'(1));
    chk("t1_resp1_pulses", 256'(resp_cnt[1] - base1), 256'(0));

    // Both ports request together; grants alternate 0,1,0 with a 3-cycle turnaround.
    do_reset();
    rq_q[0].push_back(mk_rq(32'h0000_0100, 1'b0, rand_line(), 0));
    rq_q[0].push_back(mk_rq(32'h0000_0120, 1'b0, rand_line(), 0));
    rq_q[1].push_back(mk_rq(32'h0000_0200, 1'b0, rand_line(), 0));
    run(300);
    chk("t2_cmd_count", 256'(dut_log.size()), 256'(3));
    if (dut_log.size() >= 3) begin
      chk("t2_grant0", 256'(dut_log[0].addr), 256'(32'h0000_0100));
      chk("t2_grant1", 256'(dut_log[1].addr), 256'(32'h0000_0200));
      chk("t2_grant2", 256'(dut_log[2].addr), 256'(32'h0000_0120));
    end
    if (dut_log.size() >= 3 && resp_log.size() >= 2) begin
      chk("t2_gap1", 256'(dut_log[1].cyc - resp_log[0]), 256'(3));
      chk("t2_gap2", 256'(dut_log[2].cyc - resp_log[1]), 256'(3));
    end

    // Port 1 writeback arrives while port 0's read is in flight.
    do_reset();
    rq_q[0].push_back(mk_rq(32'h0000_1000, 1'b0, rand_line(), 0));
    rq_q[1].push_back(mk_rq(32'h0000_2040, 1'b1, pat_b, 2));
    lat_q.push_back(4);
    lat_q.push_back(3);
    run(300);
    chk("t3_cmd_count", 256'(dut_log.size()), 256'(2));
    if (dut_log.size() >= 2) begin
      chk("t3_wr_addr",  256'(dut_log[1].addr), 256'(32'h0000_2040));
      chk("t3_wr_flag",  256'(dut_log[1].wr),   256'(1'b1));
      chk("t3_rd_flag",  256'(dut_log[1].rd),   256'(1'b0));
      chk("t3_wr_wdata", dut_log[1].wdata,      pat_b);
    end
    if (dut_log.size() >= 2 && resp_log.size() >= 1)
      chk("t3_after_drain", 256'(dut_log[1].cyc - resp_log[0]), 256'(3));

    // Reset in the middle of BUSY, then a stray response.
    do_reset();
    base0 = resp_cnt[0];
    bus.req_addr[0] = 32'h0000_3000;
    bus.req_read[0] = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy", 256'(bus.mem_read), 256'(1'b1));
    rst = 1'b1;
    bus.req_read[0] = 1'b0;
    @(posedge clk); #1;
    chk("t4_mem_read",  256'(bus.mem_read),  256'(1'b0));
    chk("t4_mem_write", 256'(bus.mem_write), 256'(1'b0));
    chk("t4_mem_addr",  256'(bus.mem_addr),  256'(32'h0));
    chk("t4_mem_wdata", bus.mem_wdata,       256'h0);
    rst = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    chk("t4_stray_resp", 256'(bus.req_resp), 256'(2'b00));
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
    chk("t4_still_idle", 256'(bus.mem_read | bus.mem_write), 256'(1'b0));
    // Read+write on one port is a protocol error; the arbiter must still issue it as a write.
    bus.req_addr[1]  = 32'h0000_4000;
    bus.req_wdata[1] = pat_a;
    bus.req_read[1]  = 1'b1;
    bus.req_write[1] = 1'b1;
    @(posedge clk); #1;
    chk("t4_rw_write", 256'(bus.mem_write), 256'(1'b1));
    chk("t4_rw_read",  256'(bus.mem_read),  256'(1'b0));
    chk("t4_rw_addr",  256'(bus.mem_addr),  256'(32'h0000_4000));
    bus.mem_resp = 1'b1;
    #1;
    chk("t4_rw_resp", 256'(bus.req_resp), 256'(2'b10));
    @(posedge clk); #1;
    bus.mem_resp     = 1'b0;
    bus.req_read[1]  = 1'b0;
    bus.req_write[1] = 1'b0;
    chk("t4_no_resp0", 256'(resp_cnt[0] - base0), 256'(0));

    // Randomized mixed traffic from both ports.
    do_reset();
    base0 = resp_cnt[0];
    base1 = resp_cnt[1];
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 6; k++) begin
        r = $urandom;
        rq = mk_rq({r[31:5], 5'b0}, 1'($urandom_range(0, 1)), rand_line(),
                   int'($urandom_range(0, 3)));
        rq_q[i].push_back(rq);
      end
    end
    run(2000);
    chk("rnd_resp0_total", 256'(resp_cnt[0] - base0), 256'(6));
    chk("rnd_resp1_total", 256'(resp_cnt[1] - base1), 256'(6));
    chk("rnd_cmd_total",   256'(dut_log.size()),      256'(12));

    // Watchdog: memory withholds the response for 20 cycles.
    do_reset();
    rq_q[0].push_back(mk_rq(32'h0000_5000, 1'b0, rand_line(), 0));
    lat_q.push_back(20);
    run(300);
    if (dut_log.size() >= 1)
      chk("t5_rise_cycle", 256'(to_rise - dut_log[0].cyc), 256'(TO));
    repeat (3) @(posedge clk);
    #1;
    chk("t5_sticky", 256'(arb_timeout), 256'(1'b1));
    do_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
